// File: rtl/ibex_instr_sram_bridge.sv
// ----------------------------------------------------------------------------
// ibex_instr_sram_bridge
//
// Purpose:
//   Terminates the core's instruction-side req/gnt/rvalid bus and serves
//   fetches from a single-port SoC SRAM. Requests are granted combinationally
//   and responses come back a fixed Latency cycles after the grant, strictly
//   in grant order and never backpressured. Addresses outside the SRAM window
//   get an error response (rdata=0, err=1) and issue no SRAM access.
//
// Optional feature (macro IBEX_INSTR_BRIDGE_WAIT_EN):
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset to 8'hA5)
//   randomly withholds grants to exercise the core's wait-state handling.
//   When undefined, every request is granted in the cycle it is raised.
//
// Parameters:
//   MemWords  SRAM depth in 32-bit words (power of 2)
//   BaseAddr  byte base of the SRAM window (aligned to 4*MemWords)
//   Latency   grant-to-rvalid cycles (1..3)
//
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   instr_req_i     fetch request
//   instr_gnt_o     request accepted this cycle (combinational)
//   instr_addr_i    fetch byte address, bits [1:0] ignored
//   instr_rvalid_o  response valid
//   instr_rdata_o   response word (0 on error / idle)
//   instr_err_o     response is a bus error
//   mem_req_o       SRAM read strobe
//   mem_addr_o      SRAM word address (0 when mem_req_o=0)
//   mem_rdata_i     SRAM read data, valid the cycle after mem_req_o
//   busy_o          any response in flight
// ----------------------------------------------------------------------------
module ibex_instr_sram_bridge #(
  parameter int unsigned MemWords = 1024,
  parameter logic [31:0] BaseAddr = 32'h0010_0000,
  parameter int unsigned Latency  = 1,
  localparam int unsigned AW      = $clog2(MemWords)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req_i,
  output logic          instr_gnt_o,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  logic          w_gnt;
  logic          w_hit;
  logic [29:0]   w_word_off;
  logic [31:0]   w_data;
  logic          w_unused_addr;

  // Per-stage {valid, err}; index Latency-1 drives the response outputs.
  logic [Latency-1:0] r_vld;
  logic [Latency-1:0] r_err;

  // Byte-lane bits never select anything in a word-wide fetch.
  assign w_unused_addr = ^instr_addr_i[1:0];

`ifdef IBEX_INSTR_BRIDGE_WAIT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_gnt = instr_req_i & (r_lfsr[1:0] != 2'b00);
`else
  assign w_gnt = instr_req_i;
`endif

  assign instr_gnt_o = w_gnt;

  // Offset in words from the window base, modulo 2^30: addresses below the
  // base wrap to huge offsets and therefore miss. Since MemWords is a power
  // of two, "offset < MemWords" is just "upper offset bits all zero".
  assign w_word_off = instr_addr_i[31:2] - BaseAddr[31:2];
  assign w_hit      = (w_word_off[29:AW] == '0);

  // No SRAM access while in reset, even though the grant itself is visible.
  assign mem_req_o  = w_gnt & w_hit & rst_ni;
  assign mem_addr_o = mem_req_o ? instr_addr_i[AW+1:2] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld <= '0;
      r_err <= '0;
    end else begin
      r_vld[0] <= w_gnt;
      r_err[0] <= w_gnt & ~w_hit;
      for (int i = 1; i < Latency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
      end
    end
  end

  // Data stages: with a single stage the SRAM output is already aligned with
  // the response cycle; longer latencies delay it through registers, with
  // stage 1 capturing the SRAM word.
  generate
    if (Latency == 1) begin : g_lat1
      assign w_data = mem_rdata_i;
    end else begin : g_latn
      logic [31:0] r_data [1:Latency-1];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          for (int i = 1; i < Latency; i++) begin
            r_data[i] <= '0;
          end
        end else begin
          r_data[1] <= mem_rdata_i;
          for (int i = 2; i < Latency; i++) begin
            r_data[i] <= r_data[i-1];
          end
        end
      end

      assign w_data = r_data[Latency-1];
    end
  endgenerate

  assign instr_rvalid_o = r_vld[Latency-1];
  assign instr_err_o    = r_vld[Latency-1] & r_err[Latency-1];
  // Error and idle cycles return zero rather than whatever the SRAM drives.
  assign instr_rdata_o  = (r_vld[Latency-1] && !r_err[Latency-1]) ? w_data : 32'h0;
  assign busy_o         = |r_vld;

endmodule

// File: tb/tb_ibex_instr_sram_bridge.sv
// ----------------------------------------------------------------------------
// tb_ibex_instr_sram_bridge
//
// Drives three bridges in parallel (Latency = 1, 2, 3) from one request
// stream. Each bridge has its own behavioural SRAM. The reference model keeps
// a history of granted fetches (edge number, expected err, expected word) and
// predicts, for each latency, which edge must present each response.
// ----------------------------------------------------------------------------
module tb_ibex_instr_sram_bridge;

  localparam logic [31:0] BASE      = 32'h0010_0000;
  localparam logic [31:0] WIN_BYTES = 32'h0000_1000;

  typedef struct {
    int          edge_n;
    logic        err;
    logic [31:0] data;
  } grant_t;

  logic        clk;
  logic        in_rstn;
  logic        in_req;
  logic [31:0] in_addr;

  logic        d_gnt      [3];
  logic        d_rvalid   [3];
  logic [31:0] d_rdata    [3];
  logic        d_err      [3];
  logic        d_mem_req  [3];
  logic [9:0]  d_mem_addr [3];
  logic [31:0] d_mem_rdata[3];
  logic        d_busy     [3];

  logic [31:0] mem [1024];

  grant_t      hist[$];
  int          now;
  int          n_pass;
  int          n_fail;
  int          n_total;
  bit          chk_en;
  logic [7:0]  m_lfsr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ibex_instr_sram_bridge #(
      .MemWords(1024),
      .BaseAddr(BASE),
      .Latency (gi + 1)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (in_rstn),
      .instr_req_i   (in_req),
      .instr_gnt_o   (d_gnt[gi]),
      .instr_addr_i  (in_addr),
      .instr_rvalid_o(d_rvalid[gi]),
      .instr_rdata_o (d_rdata[gi]),
      .instr_err_o   (d_err[gi]),
      .mem_req_o     (d_mem_req[gi]),
      .mem_addr_o    (d_mem_addr[gi]),
      .mem_rdata_i   (d_mem_rdata[gi]),
      .busy_o        (d_busy[gi])
    );

    // SRAM: registered read; garbage on cycles without a read strobe.
    always @(posedge clk) begin
      if (d_mem_req[gi]) d_mem_rdata[gi] <= mem[d_mem_addr[gi]];
      else               d_mem_rdata[gi] <= $urandom;
    end
  end

  task automatic chk(input string tag, input int lat, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s L=%0d edge=%0d: observed %h expected %h", tag, lat, now, obs, exp);
    end
  endtask

  function automatic bit lfsr_allows();
`ifdef IBEX_INSTR_BRIDGE_WAIT_EN
    return m_lfsr[1:0] != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  // One bus cycle: drive at negedge, check combinational outputs, advance the
  // model at posedge, then check registered outputs.
  task automatic cycle(input logic req, input logic [31:0] addr, input logic rstn);
    bit          hit;
    bit          g;
    bit          acc;
    bit          found;
    bit          busy_exp;
    grant_t      e;
    logic [31:0] widx;
    int          lat;

    @(negedge clk);
    in_req  = req;
    in_addr = addr;
    in_rstn = rstn;
    #1;
    hit  = (addr >= BASE) && (addr < BASE + WIN_BYTES);
    widx = (addr - BASE) >> 2;
    g    = req && lfsr_allows();
    acc  = g && hit && rstn;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("gnt", k + 1, {31'b0, d_gnt[k]}, {31'b0, g});
        chk("mem_req", k + 1, {31'b0, d_mem_req[k]}, {31'b0, acc});
        chk("mem_addr", k + 1, {22'b0, d_mem_addr[k]}, acc ? {22'b0, widx[9:0]} : 32'h0);
      end
    end

    @(posedge clk);
    now++;
    if (!rstn) begin
      hist.delete();
      m_lfsr = 8'hA5;
    end else begin
      if (g) hist.push_back('{now, !hit, hit ? mem[widx[9:0]] : 32'h0});
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    #1;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        lat      = k + 1;
        found    = 1'b0;
        busy_exp = 1'b0;
        e        = '{0, 1'b0, 32'h0};
        foreach (hist[i]) begin
          if (hist[i].edge_n == now - lat + 1) begin
            found = 1'b1;
            e     = hist[i];
          end
          if (hist[i].edge_n + lat - 1 >= now) busy_exp = 1'b1;
        end
        chk("rvalid", lat, {31'b0, d_rvalid[k]}, {31'b0, found});
        chk("err", lat, {31'b0, d_err[k]}, {31'b0, found && e.err});
        chk("rdata", lat, d_rdata[k], found ? e.data : 32'h0);
        chk("busy", lat, {31'b0, d_busy[k]}, {31'b0, busy_exp});
      end
    end
    while (hist.size() > 0 && hist[0].edge_n + 3 <= now) void'(hist.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic        rq;
    logic        rs;

    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    now     = 100;
    chk_en  = 1'b0;
    m_lfsr  = 8'hA5;
    in_rstn = 1'b0;
    in_req  = 1'b0;
    in_addr = 32'h0;
    foreach (mem[i]) mem[i] = $urandom;
    mem[2] = 32'hDEAD_BEEF;

    // Reset with requests present: grants during reset yield nothing.
    cycle(1'b1, BASE, 1'b0);
    chk_en = 1'b1;
    cycle(1'b1, BASE + 32'h4, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    idle(2);

    // Single fetch of word 2.
    cycle(1'b1, 32'h0010_0008, 1'b1);
    idle(4);

    // Four back-to-back fetches.
    for (int i = 0; i < 4; i++) cycle(1'b1, BASE + 32'(4 * i), 1'b1);
    idle(5);

    // Just below the window and just past its end.
    cycle(1'b1, 32'h000F_FFFC, 1'b1);
    cycle(1'b1, 32'h0010_1000, 1'b1);
    idle(4);

    // Hit / miss / hit (last word of the window).
    cycle(1'b1, BASE + 32'h10, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF0, 1'b1);
    cycle(1'b1, BASE + 32'hFFC, 1'b1);
    idle(4);

    // Reset one cycle after two grants.
    cycle(1'b1, BASE + 32'h20, 1'b1);
    cycle(1'b1, BASE + 32'h24, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    idle(4);

    // Request held high with a stable address.
    repeat (64) cycle(1'b1, BASE + 32'h40, 1'b1);
    idle(4);

    // Random traffic with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 99) < 75)
        a = BASE + {20'b0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      else
        a = $urandom;
      rq = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 59) != 0);
      cycle(rq, a, rs);
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
